bcd_asc_tx: RTL and testbench
=============================

// Module: bcd_asc_tx
// PURPOSE
//  Transmit-side inverse of the receive ASCII->BCD path: serialises a DIGITS-wide packed BCD value
//  into ASCII characters ('0'..'9') and feeds them one at a time to the UART transmitter.
//  Sits between the application/display logic and the UART TX byte interface.
//  Optional leading-zero suppression and CR/LF terminator.
// PARAMETERS
//  DIGITS       4   number of BCD digits in bcd_in (>=1)
//  SUPPRESS_LZ  1   1: skip leading zero digits; the last digit is always sent
//  SEND_CRLF    1   1: append 0x0D then 0x0A after the last digit
//  ACK_TO       16  max cycles to wait for tx_busy to rise after tx_start
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  rst       in   1         synchronous reset, active-low
//  bcd_in    in   4*DIGITS  packed BCD; most significant digit in [4*DIGITS-1 -: 4]
//  load      in   1         start request; accepted only when busy==0
//  busy      out  1         high from accept until the cycle after done
//  done      out  1         one-cycle pulse after the final char has drained
//  err       out  1         a digit >9 was seen in the current/last frame
//  tx_data   out  8         character to UART TX; stable while tx_start=1
//  tx_start  out  1         one-cycle send strobe to UART TX (registered)
//  tx_busy   in   1         UART TX busy
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): tx_data=0, tx_start=0, busy=0, done=0, err=0, FSM->IDLE.
//  Reset mid-frame aborts it: no further tx_start; a char already handed off is not recalled.
//  States: IDLE, SCAN, SEND, ACK, DRAIN, FIN.
//  IDLE:  load=1 -> capture bcd_in, idx=DIGITS-1, lead=SUPPRESS_LZ, crlf phase=0, err=0, busy=1 -> SCAN.
//  SCAN:  one digit per cycle. lead && digit==0 && idx!=0 -> idx--, stay.
//         Otherwise lead=0, tx_data=ascii(digit) -> SEND.
//  SEND:  wait tx_busy==0; then tx_start=1 for exactly that cycle -> ACK.
//  ACK:   tx_busy==1 -> DRAIN; after ACK_TO cycles without it -> DRAIN anyway.
//  DRAIN: wait tx_busy==0, then choose the next state:
//         digit phase, idx>0 -> idx--, SCAN.
//         last digit sent, SEND_CRLF=1 -> tx_data=0x0D -> SEND.
//         after CR -> tx_data=0x0A -> SEND.
//         else -> FIN.
//  FIN:   done=1 for one cycle, busy=0 from the next cycle -> IDLE.
//  ascii(d): d<=9 -> 8'h30+d; d>9 -> 8'h3F ('?') and err=1 (sticky until next accept).
//  An invalid digit counts as non-zero, so it ends leading-zero suppression.
//  Latency: load accepted at edge N with tx_busy=0 and MSD non-zero -> SCAN N+1, tx_start at N+2.
//  load while busy=1: ignored, not queued. bcd_in changes after accept: no effect.
//  load in the same cycle as FIN: ignored (busy still 1).
//  All-zero input with SUPPRESS_LZ=1 -> single '0' sent.
//  tx_start is never asserted while tx_busy=1.
// STRUCTURE
//  Package uart_pkg: ASC_ZERO=8'h30, ASC_CR=8'h0D, ASC_LF=8'h0A, ASC_QMARK=8'h3F, FSM state enum.
//  Sub-module bcd2asc (combinational): 4-bit digit -> 8-bit char + invalid flag.
//  Top: digit shift/index register, ACK timeout counter, FSM.
// TESTING (DIGITS=4, ACK_TO=16, UART model raises tx_busy 1 cycle after tx_start, holds 10 cycles)
//  1. SUPPRESS_LZ=1, SEND_CRLF=1, bcd_in=16'h0042 -> bytes 0x34,0x32,0x0D,0x0A; one done pulse; err=0.
//  2. bcd_in=16'h0000 -> 0x30,0x0D,0x0A; with SUPPRESS_LZ=0 -> 0x30,0x30,0x30,0x30,0x0D,0x0A.
//  3. bcd_in=16'h1A05 -> 0x31,0x3F,0x30,0x35,0x0D,0x0A; err=1 after the 2nd char, cleared on next load.
//  4. tx_busy forced high 20 cycles at load -> no tx_start until it drops; model that never raises
//     tx_busy -> next char starts after 16 ACK cycles.
//  5. Pulse load mid-frame with a different bcd_in -> ignored, original frame completes unchanged.
//  6. rst=0 during 2nd char -> all outputs 0 the next cycle, no further tx_start; a new load then works.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state types for the BCD-to-ASCII UART transmit path.
package uart_pkg;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SEND,
    S_ACK,
    S_DRAIN,
    S_FIN
  } state_t;

  // Which part of the frame is in flight: digits, then CR, then LF.
  typedef enum logic [1:0] {
    PH_DIG,
    PH_CR,
    PH_LF
  } phase_t;

endpackage

// File: rtl/bcd_asc_tx_bcd2asc.sv
// Combinational BCD digit to ASCII character converter; non-decimal codes become '?'.
module bcd2asc
  import uart_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] char_o,
  output logic       invalid_o
);

  assign invalid_o = (digit_i > 4'd9);
  assign char_o    = invalid_o ? ASC_QMARK : (ASC_ZERO + {4'h0, digit_i});

endmodule

// File: rtl/bcd_asc_tx.sv
// Serialises a packed BCD value into ASCII characters for a UART transmitter,
// with optional leading-zero suppression and a CR/LF terminator.
module bcd_asc_tx
  import uart_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SUPPRESS_LZ = 1,
  parameter int SEND_CRLF   = 1,
  parameter int ACK_TO      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int ACK_W = $clog2(ACK_TO + 1);

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                lead_q, lead_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [3:0]          cur_digit;
  logic [7:0]          cur_char;
  logic                cur_invalid;

  // The captured value is shifted left as digits are consumed, so the current digit is always the top nibble.
  assign cur_digit = bcd_q[4*DIGITS-1 -: 4];

  bcd2asc u_bcd2asc (
    .digit_i   (cur_digit),
    .char_o    (cur_char),
    .invalid_o (cur_invalid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_DIG;
      bcd_q      <= '0;
      idx_q      <= '0;
      lead_q     <= 1'b0;
      ack_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bcd_q      <= bcd_d;
      idx_q      <= idx_d;
      lead_q     <= lead_d;
      ack_cnt_q  <= ack_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bcd_d      = bcd_q;
    idx_d      = idx_q;
    lead_d     = lead_q;
    ack_cnt_d  = ack_cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          bcd_d   = bcd_in;
          idx_d   = IDX_W'(DIGITS - 1);
          lead_d  = (SUPPRESS_LZ != 0);
          phase_d = PH_DIG;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (lead_q && (cur_digit == 4'd0) && (idx_q != '0)) begin
          bcd_d = bcd_q << 4;
          idx_d = idx_q - 1'b1;
        end else begin
          lead_d    = 1'b0;
          tx_data_d = cur_char;
          if (cur_invalid) err_d = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          ack_cnt_d  = '0;
          state_d    = S_ACK;
        end
      end
      // A UART that never acknowledges must not stall the frame forever.
      S_ACK: begin
        if (tx_busy || (ack_cnt_q == ACK_W'(ACK_TO - 1))) begin
          state_d = S_DRAIN;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          if ((phase_q == PH_DIG) && (idx_q != '0)) begin
            bcd_d   = bcd_q << 4;
            idx_d   = idx_q - 1'b1;
            state_d = S_SCAN;
          end else if ((phase_q == PH_DIG) && (SEND_CRLF != 0)) begin
            tx_data_d = ASC_CR;
            phase_d   = PH_CR;
            state_d   = S_SEND;
          end else if (phase_q == PH_CR) begin
            tx_data_d = ASC_LF;
            phase_d   = PH_LF;
            state_d   = S_SEND;
          end else begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_bcd_asc_tx.sv
// Randomised self-checking bench for bcd_asc_tx: two instances (with and without
// leading-zero suppression) share stimulus, each feeding its own UART model.
module tb_bcd_asc_tx;

  localparam int ACK_TO = 16;
  localparam int BUF_N  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcdIn;
  logic        load;
  logic        forceBusy;
  logic        neverAck;

  logic [1:0]  busyO, doneO, errO, txStart, txBusy;
  logic [7:0]  txData [2];

  int          cycle = 0;
  int          busyCnt [2] = '{0, 0};
  int          rxCnt [2] = '{0, 0};
  int          violations [2] = '{0, 0};
  logic [7:0]  rxBuf [2][BUF_N];
  int          startEdge [2][BUF_N];
  int          lastBase [2];

  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  bcd_asc_tx #(.DIGITS(4), .SUPPRESS_LZ(1), .SEND_CRLF(1), .ACK_TO(ACK_TO)) dutLz (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcdIn),
    .load     (load),
    .busy     (busyO[0]),
    .done     (doneO[0]),
    .err      (errO[0]),
    .tx_data  (txData[0]),
    .tx_start (txStart[0]),
    .tx_busy  (txBusy[0])
  );

  bcd_asc_tx #(.DIGITS(4), .SUPPRESS_LZ(0), .SEND_CRLF(1), .ACK_TO(ACK_TO)) dutAll (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcdIn),
    .load     (load),
    .busy     (busyO[1]),
    .done     (doneO[1]),
    .err      (errO[1]),
    .tx_data  (txData[1]),
    .tx_start (txStart[1]),
    .tx_busy  (txBusy[1])
  );

  assign txBusy[0] = (busyCnt[0] > 0) || forceBusy;
  assign txBusy[1] = (busyCnt[1] > 0) || forceBusy;

  // UART model: busy rises the edge after tx_start and holds for 10 cycles (unless neverAck).
  always @(posedge clk) begin
    cycle <= cycle + 1;
    for (int i = 0; i < 2; i++) begin
      if (txStart[i]) begin
        if (txBusy[i]) violations[i] <= violations[i] + 1;
        if (rxCnt[i] < BUF_N) begin
          rxBuf[i][rxCnt[i]]     <= txData[i];
          startEdge[i][rxCnt[i]] <= cycle;
        end
        rxCnt[i]   <= rxCnt[i] + 1;
        busyCnt[i] <= neverAck ? 0 : 10;
      end else if (busyCnt[i] > 0) begin
        busyCnt[i] <= busyCnt[i] - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the character sequence a frame should produce, from the digit values alone.
  function automatic int modelFrame(input logic [15:0] v, input bit sup,
                                    output logic [7:0] chars [6], output bit bad);
    int first = 0;
    int n = 0;
    logic [3:0] d;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) chars[k] = 8'h00;
    if (sup) begin
      while (first < 3 && v[15-4*first -: 4] == 4'd0) first++;
    end
    for (int k = first; k < 4; k++) begin
      d = v[15-4*k -: 4];
      if (d > 4'd9) begin
        chars[n] = 8'h3F;
        bad = 1'b1;
      end else begin
        chars[n] = 8'h30 + {4'h0, d};
      end
      n++;
    end
    chars[n]   = 8'h0D;
    chars[n+1] = 8'h0A;
    return n + 2;
  endfunction

  task automatic applyStimulus(input logic [15:0] v, input int forceCycles, input bit midLoad);
    logic [7:0] exp [6];
    int n;
    bit bad;
    int base [2];
    int vbase [2];
    int doneCnt [2];
    bit fin [2];
    int acc;
    for (int ch = 0; ch < 2; ch++) begin
      base[ch]     = rxCnt[ch];
      vbase[ch]    = violations[ch];
      doneCnt[ch]  = 0;
      fin[ch]      = 1'b0;
      lastBase[ch] = rxCnt[ch];
    end
    @(negedge clk);
    bcdIn     = v;
    load      = 1'b1;
    forceBusy = (forceCycles > 0);
    @(posedge clk);
    acc = cycle;
    @(negedge clk);
    load  = 1'b0;
    bcdIn = 16'($urandom);
    for (int ch = 0; ch < 2; ch++) begin
      checkOutput("errClearOnLoad", 32'(errO[ch]), 32'(0));
      checkOutput("busyAfterLoad", 32'(busyO[ch]), 32'(1));
    end
    if (forceCycles > 0) begin
      repeat (forceCycles) @(negedge clk);
      for (int ch = 0; ch < 2; ch++)
        checkOutput("noStartWhileBusy", 32'(rxCnt[ch] - base[ch]), 32'(0));
      forceBusy = 1'b0;
    end
    if (midLoad) begin
      repeat (6) @(negedge clk);
      bcdIn = ~v;
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
    for (int c = 0; c < 1000 && !(fin[0] && fin[1]); c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (doneO[ch]) doneCnt[ch]++;
        if (doneCnt[ch] > 0 && !busyO[ch]) fin[ch] = 1'b1;
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      checkOutput("frameFinished", 32'(fin[ch]), 32'(1));
      n = modelFrame(v, (ch == 0), exp, bad);
      checkOutput("charCount", 32'(rxCnt[ch] - base[ch]), 32'(n));
      for (int k = 0; k < n; k++)
        checkOutput("char", 32'(rxBuf[ch][base[ch]+k]), 32'(exp[k]));
      checkOutput("donePulses", 32'(doneCnt[ch]), 32'(1));
      checkOutput("errFlag", 32'(errO[ch]), 32'(bad));
      checkOutput("startDuringBusy", 32'(violations[ch] - vbase[ch]), 32'(0));
      if (forceCycles == 0 && (ch == 1 || v[15:12] != 4'd0))
        checkOutput("startLatency", 32'(startEdge[ch][base[ch]] - acc), 32'(3));
    end
  endtask

  task automatic resetMidFrame();
    int base [2];
    bit reached = 1'b0;
    base[0] = rxCnt[0];
    base[1] = rxCnt[1];
    @(negedge clk);
    bcdIn = 16'h1A34;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      @(negedge clk);
      if (rxCnt[1] - base[1] >= 2) reached = 1'b1;
    end
    checkOutput("secondCharReached", 32'(reached), 32'(1));
    for (int ch = 0; ch < 2; ch++) checkOutput("errBeforeReset", 32'(errO[ch]), 32'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      checkOutput("rstTxStart", 32'(txStart[ch]), 32'(0));
      checkOutput("rstTxData", 32'(txData[ch]), 32'(0));
      checkOutput("rstBusy", 32'(busyO[ch]), 32'(0));
      checkOutput("rstDone", 32'(doneO[ch]), 32'(0));
      checkOutput("rstErr", 32'(errO[ch]), 32'(0));
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      checkOutput("noStartAfterReset", 32'(rxCnt[ch] - base[ch]), 32'(2));
      checkOutput("idleAfterReset", 32'(busyO[ch]), 32'(0));
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [3:0]  d;
    int          sel;
    rst       = 1'b0;
    load      = 1'b0;
    bcdIn     = 16'h0;
    forceBusy = 1'b0;
    neverAck  = 1'b0;
    repeat (3) @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      checkOutput("resetBusy", 32'(busyO[ch]), 32'(0));
      checkOutput("resetDone", 32'(doneO[ch]), 32'(0));
      checkOutput("resetErr", 32'(errO[ch]), 32'(0));
      checkOutput("resetTxStart", 32'(txStart[ch]), 32'(0));
      checkOutput("resetTxData", 32'(txData[ch]), 32'(0));
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(16'h0042, 0, 1'b0);
    applyStimulus(16'h0000, 0, 1'b0);
    applyStimulus(16'h1A05, 0, 1'b0);
    applyStimulus(16'h0907, 0, 1'b0);
    applyStimulus(16'h3000, 20, 1'b0);

    neverAck = 1'b1;
    applyStimulus(16'h5678, 0, 1'b0);
    for (int ch = 0; ch < 2; ch++)
      checkOutput("ackTimeoutSpacing",
                  32'(startEdge[ch][lastBase[ch]+1] - startEdge[ch][lastBase[ch]]), 32'(ACK_TO + 3));
    neverAck = 1'b0;

    applyStimulus(16'h2468, 0, 1'b1);
    resetMidFrame();
    applyStimulus(16'h0100, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      v = 16'h0;
      for (int k = 0; k < 4; k++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 3)       d = 4'd0;
        else if (sel == 3) d = 4'($urandom_range(10, 15));
        else               d = 4'($urandom_range(0, 9));
        v = {v[11:0], d};
      end
      applyStimulus(v, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 12)) : 0,
                    ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
